// File: rtl/request_dispatcher_pkg.sv
// request_dispatcher shared types and constants
// Request count, index width and the dispatcher FSM encoding
package request_dispatcher_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/request_dispatcher_prio.sv
// prio_enc16_comb: 16-to-4 priority encoder, bit 15 wins
// idx is meaningless when z is low
module prio_enc16_comb
  import request_dispatcher_pkg::*;
(
  input  logic [N_REQ-1:0] in_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             z_o
);

  // Ascending scan so the highest set bit is the last write
  always_comb begin
    idx_o = '0;
    z_o   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (in_i[i]) begin
        idx_o = IDX_W'(i);
        z_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_dispatcher.sv
// request_dispatcher: latches request pulses, masks them and
// offers the highest eligible index on a valid/ready handshake
module request_dispatcher
  import request_dispatcher_pkg::*;
#(
  parameter int N_REQ = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             mask_we,
  input  logic [N_REQ-1:0] mask_in,
  input  logic             ready,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] pending,
  output logic             any_pending,
  output logic [CNT_W-1:0] served_cnt
);

  state_e           state_q;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] pend_q;
  logic [N_REQ-1:0] pend_d;
  logic [N_REQ-1:0] mask_q;
  logic [N_REQ-1:0] mask_d;
  logic             any_q;
  logic [N_REQ-1:0] clr_vec;
  logic [N_REQ-1:0] eligible;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_z;
  logic             hs;

  assign hs       = valid_q & ready;
  assign eligible = pend_q & mask_q;

  prio_enc16_comb u_enc (
    .in_i  (eligible),
    .idx_o (enc_idx),
    .z_o   (enc_z)
  );

  // Clear the accepted bit; a same-edge request re-sets it
  always_comb begin
    clr_vec = '0;
    if (hs) clr_vec[idx_q] = 1'b1;
    pend_d = (pend_q & ~clr_vec) | req;
    mask_d = mask_we ? mask_in : mask_q;
  end

  // Pending, mask and the registered any-eligible flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      mask_q <= '1;
      any_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      any_q  <= |(pend_d & mask_d);
    end
  end

  // Offer FSM: select in IDLE, hold the offer until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enc_z) begin
            idx_q   <= enc_idx;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (ready) begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign valid       = valid_q;
  assign idx         = idx_q;
  assign pending     = pend_q;
  assign any_pending = any_q;
  assign served_cnt  = cnt_q;

endmodule

// File: tb/tb_request_dispatcher.sv
// tb_request_dispatcher: directed stimulus, per-cycle model compare
// plus literal expectations from the test plan
module tb_request_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        mask_we;
  logic [15:0] mask_in;
  logic        ready;
  logic        valid;
  logic [3:0]  idx;
  logic [15:0] pending;
  logic        any_pending;
  logic [7:0]  served_cnt;

  int checks = 0;
  int errors = 0;

  request_dispatcher #(.N_REQ(16), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .mask_we     (mask_we),
    .mask_in     (mask_in),
    .ready       (ready),
    .valid       (valid),
    .idx         (idx),
    .pending     (pending),
    .any_pending (any_pending),
    .served_cnt  (served_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // Behavioural model: a set of pending requests, one outstanding
  // offer at most, and a served count modulo 256
  bit        m_on = 1'b0;
  bit        m_valid;
  int        m_idx;
  bit [15:0] m_pend;
  bit [15:0] m_mask;
  int        m_cnt;
  bit        m_any;

  always @(posedge clk) begin
    bit [15:0] np;
    bit [15:0] nm;
    bit [15:0] el;
    int        best;
    if (rst) begin
      m_on    <= 1'b1;
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_pend  <= 16'h0;
      m_mask  <= 16'hFFFF;
      m_cnt   <= 0;
      m_any   <= 1'b0;
    end else if (m_on) begin
      np = m_pend;
      if (m_valid && ready) np[m_idx] = 1'b0;
      np = np | req;
      nm = mask_we ? mask_in : m_mask;
      if (m_valid) begin
        if (ready) begin
          m_valid <= 1'b0;
          m_cnt   <= (m_cnt + 1) % 256;
        end
      end else begin
        el   = m_pend & m_mask;
        best = -1;
        for (int b = 15; b >= 0; b--)
          if (best < 0 && el[b]) best = b;
        if (best >= 0) begin
          m_valid <= 1'b1;
          m_idx   <= best;
        end
      end
      m_pend <= np;
      m_mask <= nm;
      m_any  <= (np & nm) != 16'h0;
    end
  end

  // Single compare process against the model
  always @(negedge clk) begin
    if (m_on && !rst) begin
      chk("m_valid", valid, m_valid);
      chk("m_idx", idx, m_idx);
      chk("m_pending", pending, m_pend);
      chk("m_any", any_pending, m_any);
      chk("m_cnt", served_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(string nm);
    int n = 0;
    while (valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, valid, 1);
  endtask

  initial begin
    rst = 1'b1; req = '0; mask_we = 0; mask_in = '0; ready = 0;
    tick(); tick();
    rst = 1'b0;

    // reset then idle
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0 || i == 9) begin
        chk("rst_valid", valid, 0);
        chk("rst_idx", idx, 0);
        chk("rst_pend", pending, 0);
        chk("rst_cnt", served_cnt, 0);
        chk("rst_any", any_pending, 0);
      end
    end

    // priority order
    ready = 1; req = 16'h8421;
    tick();
    req = '0;
    chk("prio_lat", valid, 0);
    tick();
    chk("prio_first", valid, 1);
    for (int k = 0; k < 4; k++) begin
      wait_valid("prio");
      chk("prio_idx", idx, 15 - 5 * k);
      tick();
      chk("prio_gap", valid, 0);
    end
    tick();
    chk("prio_cnt", served_cnt, 4);
    chk("prio_pend", pending, 0);

    // backpressure and no retraction
    ready = 0; req = 16'h0008;
    tick();
    req = '0;
    wait_valid("bp");
    chk("bp_idx", idx, 3);
    req = 16'h1000;
    tick();
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", idx, 3);
      chk("bp_hold_v", valid, 1);
    end
    ready = 1;
    tick();
    wait_valid("bp2");
    chk("bp_next", idx, 12);
    tick();
    ready = 0;
    chk("bp_cnt", served_cnt, 6);

    // mask
    mask_we = 1; mask_in = 16'h00FF;
    tick();
    mask_we = 0; ready = 1; req = 16'hFF01;
    tick();
    req = '0;
    wait_valid("mask");
    chk("mask_idx", idx, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mask_quiet", valid, 0);
    end
    chk("mask_pend", pending, 16'hFF00);
    chk("mask_any", any_pending, 0);
    mask_we = 1; mask_in = 16'hFFFF;
    tick();
    mask_we = 0;
    for (int k = 15; k >= 8; k--) begin
      wait_valid("unmask");
      chk("unmask_idx", idx, k);
      tick();
    end
    tick();
    chk("unmask_cnt", served_cnt, 15);

    // same-cycle re-request
    ready = 0; req = 16'h0080;
    tick();
    req = '0;
    wait_valid("rr");
    chk("rr_idx", idx, 7);
    ready = 1; req = 16'h0080;
    tick();
    req = '0; ready = 0;
    chk("rr_pend", pending[7], 1);
    chk("rr_drop", valid, 0);
    chk("rr_cnt1", served_cnt, 16);
    tick();
    chk("rr_again", valid, 1);
    chk("rr_idx2", idx, 7);
    ready = 1;
    tick();
    chk("rr_cnt2", served_cnt, 17);
    chk("rr_pend2", pending, 0);

    // counter wrap: 239 more handshakes bring 17 back to 0
    req = 16'h0001;
    for (int k = 0; k < 239; k++) begin
      wait_valid("wrap");
      if (k == 238) chk("wrap_255", served_cnt, 255);
      tick();
    end
    ready = 0; req = '0;
    chk("wrap_zero", served_cnt, 0);

    // reset mid-offer
    wait_valid("mid");
    chk("mid_pend", pending[0], 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_valid", valid, 0);
    chk("mid_pend0", pending, 0);
    chk("mid_cnt", served_cnt, 0);
    tick(); tick();
    chk("mid_idle", valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
